div_result_bcd_conv: RTL and testbench

- Downstream stage of the 8-bit divider. Captures one quotient/remainder pair per transaction.
- Converts both values in parallel to 3-digit packed BCD using an iterative double-dabble (shift-and-add-3).
- Presents the BCD result on a valid/ready interface for display or logging logic.
- One conversion in flight at a time.

---
 rtl/div_bcd_pkg.sv | 21 ++
 rtl/bcd_dabble_step.sv | 32 +++
 rtl/div_result_bcd_conv.sv | 171 +++++++++++++++++
 tb/tb_div_result_bcd_conv.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_bcd_pkg.sv
// Shared definitions for the divider-result BCD converter: default widths,
// converter state encoding and the per-digit add-3 correction.
// Optional feature macro used by the top: DIV_BCD_BLANK_EN.
package div_bcd_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DIGITS_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // A digit of 5 or more would reach 10+ when doubled, so pre-bias it by 3
    // so the carry lands in the next digit after the shift.
    function automatic logic [3:0] add3_digit(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration for a single {bcd,bin} pair:
// add-3 correction on every BCD digit, then a 1-bit left shift of the
// concatenated accumulator and binary shift register.
module bcd_dabble_step
    import div_bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    input  logic [WIDTH-1:0]    bin_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic [WIDTH-1:0]    bin_o
);

    logic [4*DIGITS-1:0]       corr;
    logic [4*DIGITS+WIDTH-1:0] shifted;

    // Correct each digit independently before the shift.
    always_comb begin
        corr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            corr[4*i +: 4] = add3_digit(bcd_i[4*i +: 4]);
        end
    end

    // The top digit never carries out because DIGITS covers 2^WIDTH-1.
    assign shifted = {corr, bin_i} << 1;
    assign bcd_o   = shifted[4*DIGITS+WIDTH-1:WIDTH];
    assign bin_o   = shifted[WIDTH-1:0];

endmodule

// File: rtl/div_result_bcd_conv.sv
// Downstream stage of the 8-bit divider: captures one quotient/remainder
// pair, converts both to packed BCD with an iterative double-dabble (one
// iteration per clock) and presents the result on a valid/ready output.
// Optional feature: define DIV_BCD_BLANK_EN to add leading-zero blank masks.
//
// Handshake: an input pair transfers on a rising edge where in_valid and
// in_ready are both 1; a result transfers on a rising edge where out_valid
// and out_ready are both 1. in_ready is 1 only in IDLE, out_valid only in
// DONE, so exactly one conversion is in flight and the other side's strobe
// is ignored outside its state.
module div_result_bcd_conv
    import div_bcd_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEF,
    localparam int DIGITS = (WIDTH * 30103 + 99999) / 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    quotient,
    input  logic [WIDTH-1:0]    remainder,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] q_bcd,
    output logic [4*DIGITS-1:0] r_bcd,
    output logic [1:0]          dbg_state_o
`ifdef DIV_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]   q_blank,
    output logic [DIGITS-1:0]   r_blank
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    conv_state_t         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    qbin_q, qbin_d, rbin_q, rbin_d;
    logic [4*DIGITS-1:0] qacc_q, qacc_d, racc_q, racc_d;
    logic [4*DIGITS-1:0] q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;

    logic [4*DIGITS-1:0] qacc_step, racc_step;
    logic [WIDTH-1:0]    qbin_step, rbin_step;

`ifdef DIV_BCD_BLANK_EN
    logic [DIGITS-1:0] q_blank_q, q_blank_d, r_blank_q, r_blank_d;

    // Bit i is set when digit i and every digit above it are zero; digit 0
    // is never blanked so a zero value still shows one "0".
    function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] bcd);
        logic zero_above;
        zero_above = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (bcd[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_above;
        end
    endfunction
`endif

    bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q_step (
        .bcd_i (qacc_q),
        .bin_i (qbin_q),
        .bcd_o (qacc_step),
        .bin_o (qbin_step)
    );

    bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r_step (
        .bcd_i (racc_q),
        .bin_i (rbin_q),
        .bcd_o (racc_step),
        .bin_o (rbin_step)
    );

    // State, shift registers and result registers; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            qbin_q    <= '0;
            rbin_q    <= '0;
            qacc_q    <= '0;
            racc_q    <= '0;
            q_bcd_q   <= '0;
            r_bcd_q   <= '0;
`ifdef DIV_BCD_BLANK_EN
            q_blank_q <= '0;
            r_blank_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qbin_q    <= qbin_d;
            rbin_q    <= rbin_d;
            qacc_q    <= qacc_d;
            racc_q    <= racc_d;
            q_bcd_q   <= q_bcd_d;
            r_bcd_q   <= r_bcd_d;
`ifdef DIV_BCD_BLANK_EN
            q_blank_q <= q_blank_d;
            r_blank_q <= r_blank_d;
`endif
        end
    end

    // Next-state logic: load on accept, iterate WIDTH times, hold until consumed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qbin_d    = qbin_q;
        rbin_d    = rbin_q;
        qacc_d    = qacc_q;
        racc_d    = racc_q;
        q_bcd_d   = q_bcd_q;
        r_bcd_d   = r_bcd_q;
`ifdef DIV_BCD_BLANK_EN
        q_blank_d = q_blank_q;
        r_blank_d = r_blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    qbin_d  = quotient;
                    rbin_d  = remainder;
                    qacc_d  = '0;
                    racc_d  = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                qbin_d = qbin_step;
                rbin_d = rbin_step;
                qacc_d = qacc_step;
                racc_d = racc_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    q_bcd_d   = qacc_step;
                    r_bcd_d   = racc_step;
`ifdef DIV_BCD_BLANK_EN
                    q_blank_d = blank_mask(qacc_step);
                    r_blank_d = blank_mask(racc_step);
`endif
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign q_bcd       = q_bcd_q;
    assign r_bcd       = r_bcd_q;
    assign dbg_state_o = state_q;
`ifdef DIV_BCD_BLANK_EN
    assign q_blank     = q_blank_q;
    assign r_blank     = r_blank_q;
`endif

endmodule

// File: tb/tb_div_result_bcd_conv.sv
// Bench for div_result_bcd_conv: directed scenarios plus randomized traffic
// with random output backpressure; expected results come from decimal
// arithmetic on the input values and are checked by an output monitor.
module tb_div_result_bcd_conv;
    import div_bcd_pkg::*;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int EW = 2*D + 8*D;   // {q_blank, r_blank, q_bcd, r_bcd}

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           out_valid;
    logic           out_ready;
    logic [4*D-1:0] q_bcd;
    logic [4*D-1:0] r_bcd;
    logic [1:0]     dbg_state;
`ifdef DIV_BCD_BLANK_EN
    logic [D-1:0]   q_blank;
    logic [D-1:0]   r_blank;
`endif

    logic [EW-1:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;
    bit rand_bp = 1'b0;

    div_result_bcd_conv dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q_bcd       (q_bcd),
        .r_bcd       (r_bcd),
        .dbg_state_o (dbg_state)
`ifdef DIV_BCD_BLANK_EN
        ,
        .q_blank     (q_blank),
        .r_blank     (r_blank)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int rem;
        rem = v;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] to_blank(input int v);
        logic [D-1:0] b;
        int lim;
        b = '0;
        lim = 10;
        for (int i = 1; i < D; i++) begin
            b[i] = (v < lim);
            lim = lim * 10;
        end
        return b;
    endfunction

    function automatic logic [EW-1:0] model(input int q, input int r);
        return {to_blank(q), to_blank(r), to_bcd(q), to_bcd(r)};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every accepted result is popped and compared.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got q=%0h r=%0h with nothing expected", q_bcd, r_bcd);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("q_bcd", 32'(q_bcd), 32'(e[8*D-1:4*D]));
                check("r_bcd", 32'(r_bcd), 32'(e[4*D-1:0]));
`ifdef DIV_BCD_BLANK_EN
                check("q_blank", 32'(q_blank), 32'(e[EW-1:EW-D]));
                check("r_blank", 32'(r_blank), 32'(e[EW-D-1:8*D]));
`endif
            end
        end
    end

    // Random output backpressure during the random phase.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int q, input int r, input bit chk_lat);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        quotient  = W'(q);
        remainder = W'(r);
        exp_q.push_back(model(q, r));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        quotient  = W'($urandom);
        remainder = W'($urandom);
        if (chk_lat) begin
            n = 0;
            while (!out_valid && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            check("latency", 32'(n), 32'(W));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready && exp_q.size() == 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        quotient  = '0;
        remainder = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_q_bcd", 32'(q_bcd), 32'd0);
        check("rst_r_bcd", 32'(r_bcd), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero and small value, latency and in_ready recovery.
        send(0, 5, 1'b1);
        @(posedge clk); #1;
        check("t1_in_ready_after", 32'(in_ready), 32'd1);
        check("t1_out_valid_after", 32'(out_valid), 32'd0);

        // Extremes and digit-boundary values.
        send(255, 254, 1'b0);
        send(100, 99, 1'b0);
        wait_idle();

        // Backpressure in DONE with ignored input pulses.
        out_ready = 1'b0;
        send(123, 45, 1'b0);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            quotient  = W'($urandom);
            remainder = W'($urandom);
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_q_bcd", 32'(q_bcd), 32'(to_bcd(123)));
            check("bp_r_bcd", 32'(r_bcd), 32'(to_bcd(45)));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released_valid", 32'(out_valid), 32'd0);
        check("bp_released_ready", 32'(in_ready), 32'd1);
        check("bp_single_consume", 32'(exp_q.size()), 32'd0);

        // Inputs changing after the accept edge must not matter.
        send(37, 150, 1'b0);
        quotient  = 8'd200;
        remainder = 8'd3;
        wait_idle();
        check("hold_after_idle", 32'(q_bcd), 32'(to_bcd(37)));

        // Reset on the 4th SHIFT cycle aborts the conversion.
        send(77, 88, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_q_bcd", 32'(q_bcd), 32'd0);
        check("abort_r_bcd", 32'(r_bcd), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(13, 2, 1'b1);
        wait_idle();

        // Values exercising the blank masks.
        send(7, 0, 1'b0);
        send(0, 10, 1'b0);
        send(120, 9, 1'b0);
        wait_idle();

        // Random traffic with random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
